// File: rtl/wasm_frame_pkg.sv
// Shared types for the call/return frame controller: request opcodes, completion
// codes, controller states and the frame record kept in the private LIFO.
package wasm_frame_pkg;

  localparam int DEF_ST_LOG2_DEPTH    = 8;
  localparam int DEF_ST_WIDTH         = 32;
  localparam int DEF_PC_WIDTH         = 16;
  localparam int DEF_FRAME_LOG2_DEPTH = 4;

  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_RETURN = 2'b10;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_FRAME_OVF  = 3'd1;
  localparam logic [2:0] ERR_FRAME_UNF  = 3'd2;
  localparam logic [2:0] ERR_PARAM_UNF  = 3'd3;
  localparam logic [2:0] ERR_STACK_OVF  = 3'd4;
  localparam logic [2:0] ERR_RESULT_UNF = 3'd5;
  localparam logic [2:0] ERR_OP         = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_CALL, S_RET_CAP, S_RET_UNWIND, S_RET_PUSH, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic [DEF_PC_WIDTH-1:0]    return_pc;
    logic [DEF_ST_LOG2_DEPTH:0] callee_base;
    logic [DEF_ST_LOG2_DEPTH:0] caller_base;
    logic [1:0]                 result_num;
  } frame_rec_t;

  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == OP_CALL) || (op == OP_RETURN);
  endfunction

endpackage

// File: rtl/frame_record_stack.sv
// Register-based LIFO of frame records; push and pop are never requested together.
module frame_record_stack #(
  parameter int W          = 36,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        push_data,
  output logic [W-1:0]        top_data,
  output logic                full,
  output logic                empty,
  output logic [LOG2_DEPTH:0] count
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;

  logic [W-1:0]          mem_q [DEPTH];
  logic [W-1:0]          mem_d [DEPTH];
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic [LOG2_DEPTH-1:0] wr_idx, rd_idx;

  assign wr_idx   = count_q[LOG2_DEPTH-1:0];
  assign rd_idx   = wr_idx - LOG2_DEPTH'(1);
  assign full     = count_q[LOG2_DEPTH];
  assign empty    = (count_q == (LOG2_DEPTH+1)'(0));
  assign top_data = mem_q[rd_idx];
  assign count    = count_q;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      count_d       = count_q + (LOG2_DEPTH+1)'(1);
    end else if (pop && !empty) begin
      count_d = count_q - (LOG2_DEPTH+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/frame_controller.sv
// Call/return sequencer driving the shared operand stack during CALL/RETURN.
// Optional FRAME_STATS_EN adds max-depth and call-count statistics outputs.
module frame_controller
  import wasm_frame_pkg::*;
#(
  parameter int ST_LOG2_DEPTH    = DEF_ST_LOG2_DEPTH,
  parameter int ST_WIDTH         = DEF_ST_WIDTH,
  parameter int PC_WIDTH         = DEF_PC_WIDTH,
  parameter int FRAME_LOG2_DEPTH = DEF_FRAME_LOG2_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_op,
  input  logic [7:0]                  req_param_num,
  input  logic [7:0]                  req_local_num,
  input  logic [1:0]                  req_result_num,
  input  logic [PC_WIDTH-1:0]         req_return_pc,
  input  logic [ST_LOG2_DEPTH:0]      st_top_pointer,
  input  logic [ST_WIDTH-1:0]         st_pop_window_a,
  input  logic [ST_WIDTH-1:0]         st_pop_window_b,
  input  logic [ST_WIDTH-1:0]         st_pop_window_c,
  output logic                        st_ctrl_active,
  output logic                        st_call,
  output logic                        st_return,
  output logic [7:0]                  st_alloc_size,
  output logic [ST_WIDTH-1:0]         st_function_stack_tag,
  output logic                        st_push_num,
  output logic [ST_WIDTH-1:0]         st_push_data,
  output logic [ST_LOG2_DEPTH:0]      local_base,
  output logic [FRAME_LOG2_DEPTH:0]   frame_depth,
`ifdef FRAME_STATS_EN
  output logic [FRAME_LOG2_DEPTH:0]   stat_max_depth,
  output logic [31:0]                 stat_call_count,
`endif
  output logic                        done_valid,
  output logic                        done_err,
  output logic [2:0]                  done_err_code,
  output logic [PC_WIDTH-1:0]         done_return_pc
);

  state_t                    state_q, state_d;
  frame_rec_t                rec_q, rec_d, lifo_top;
  logic                      is_ret_q, is_ret_d;
  logic [7:0]                alloc_q, alloc_d;
  logic [2:0]                err_code_q, err_code_d, check_code;
  logic [ST_WIDTH-1:0]       buf_a_q, buf_a_d, buf_b_q, buf_b_d, buf_c_q, buf_c_d;
  logic [1:0]                push_cnt_q, push_cnt_d;
  logic [ST_LOG2_DEPTH:0]    local_base_q, local_base_d;
  logic                      lifo_push, lifo_pop, lifo_full, lifo_empty;
  logic [FRAME_LOG2_DEPTH:0] lifo_count;
  logic [ST_LOG2_DEPTH:0]    param_ext, callee_base_s, ret_avail;
  logic [ST_LOG2_DEPTH+1:0]  top_plus_local;

  frame_record_stack #(.W($bits(frame_rec_t)), .LOG2_DEPTH(FRAME_LOG2_DEPTH)) u_lifo (
    .clk(clk), .rst(rst), .push(lifo_push), .pop(lifo_pop), .push_data(rec_q),
    .top_data(lifo_top), .full(lifo_full), .empty(lifo_empty), .count(lifo_count)
  );

  // Stack-top arithmetic is one bit wider than the pointer so overflow is visible.
  assign param_ext      = (ST_LOG2_DEPTH+1)'(req_param_num);
  assign callee_base_s  = st_top_pointer - param_ext;
  assign top_plus_local = (ST_LOG2_DEPTH+2)'(st_top_pointer) + (ST_LOG2_DEPTH+2)'(req_local_num);
  assign ret_avail      = st_top_pointer - local_base_q;

  always_comb begin
    check_code = ERR_NONE;
    if (!is_valid_op(req_op)) begin
      check_code = ERR_OP;
    end else if (req_op == OP_CALL && lifo_full) begin
      check_code = ERR_FRAME_OVF;
    end else if (req_op == OP_CALL && st_top_pointer < param_ext) begin
      check_code = ERR_PARAM_UNF;
    end else if (req_op == OP_CALL && top_plus_local > (ST_LOG2_DEPTH+2)'(2 ** ST_LOG2_DEPTH)) begin
      check_code = ERR_STACK_OVF;
    end else if (req_op == OP_RETURN && lifo_empty) begin
      check_code = ERR_FRAME_UNF;
    end else if (req_op == OP_RETURN && ret_avail < (ST_LOG2_DEPTH+1)'(lifo_top.result_num)) begin
      check_code = ERR_RESULT_UNF;
    end else begin
      check_code = ERR_NONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    rec_d        = rec_q;
    is_ret_d     = is_ret_q;
    alloc_d      = alloc_q;
    err_code_d   = err_code_q;
    buf_a_d      = buf_a_q;
    buf_b_d      = buf_b_q;
    buf_c_d      = buf_c_q;
    push_cnt_d   = push_cnt_q;
    local_base_d = local_base_q;
    lifo_push    = 1'b0;
    lifo_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          alloc_d    = req_local_num;
          is_ret_d   = (req_op == OP_RETURN);
          err_code_d = check_code;
          if (req_op == OP_RETURN) begin
            rec_d = lifo_top;
          end else begin
            rec_d = '{return_pc: req_return_pc, callee_base: callee_base_s,
                      caller_base: local_base_q, result_num: req_result_num};
          end
          if (check_code != ERR_NONE) state_d = S_ERR;
          else if (req_op == OP_RETURN) state_d = S_RET_CAP;
          else state_d = S_CALL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALL: begin
        lifo_push    = 1'b1;
        local_base_d = rec_q.callee_base;
        state_d      = S_DONE;
      end
      S_RET_CAP: begin
        buf_a_d    = st_pop_window_a;
        buf_b_d    = st_pop_window_b;
        buf_c_d    = st_pop_window_c;
        push_cnt_d = rec_q.result_num;
        state_d    = S_RET_UNWIND;
      end
      S_RET_UNWIND: begin
        lifo_pop     = 1'b1;
        local_base_d = rec_q.caller_base;
        if (push_cnt_q == 2'd0) state_d = S_DONE;
        else state_d = S_RET_PUSH;
      end
      S_RET_PUSH: begin
        push_cnt_d = push_cnt_q - 2'd1;
        if (push_cnt_q == 2'd1) state_d = S_DONE;
        else state_d = S_RET_PUSH;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rec_q        <= '0;
      is_ret_q     <= 1'b0;
      alloc_q      <= 8'd0;
      err_code_q   <= ERR_NONE;
      buf_a_q      <= '0;
      buf_b_q      <= '0;
      buf_c_q      <= '0;
      push_cnt_q   <= 2'd0;
      local_base_q <= '0;
    end else begin
      state_q      <= state_d;
      rec_q        <= rec_d;
      is_ret_q     <= is_ret_d;
      alloc_q      <= alloc_d;
      err_code_q   <= err_code_d;
      buf_a_q      <= buf_a_d;
      buf_b_q      <= buf_b_d;
      buf_c_q      <= buf_c_d;
      push_cnt_q   <= push_cnt_d;
      local_base_q <= local_base_d;
    end
  end

  // Outputs decode from registered state only; remaining count selects C, B, A in turn.
  always_comb begin
    req_ready             = (state_q == S_IDLE);
    st_ctrl_active        = 1'b0;
    st_call               = 1'b0;
    st_return             = 1'b0;
    st_alloc_size         = 8'd0;
    st_function_stack_tag = '0;
    st_push_num           = 1'b0;
    st_push_data          = '0;
    done_valid            = 1'b0;
    done_err              = 1'b0;
    done_err_code         = ERR_NONE;
    done_return_pc        = '0;
    case (state_q)
      S_CALL: begin
        st_ctrl_active = 1'b1;
        st_call        = 1'b1;
        st_alloc_size  = alloc_q;
      end
      S_RET_UNWIND: begin
        st_ctrl_active        = 1'b1;
        st_return             = 1'b1;
        st_function_stack_tag = ST_WIDTH'(rec_q.callee_base);
      end
      S_RET_PUSH: begin
        st_ctrl_active = 1'b1;
        st_push_num    = 1'b1;
        case (push_cnt_q)
          2'd3:    st_push_data = buf_c_q;
          2'd2:    st_push_data = buf_b_q;
          2'd1:    st_push_data = buf_a_q;
          default: st_push_data = '0;
        endcase
      end
      S_DONE: begin
        done_valid     = 1'b1;
        done_return_pc = is_ret_q ? rec_q.return_pc : '0;
      end
      S_ERR: begin
        done_valid    = 1'b1;
        done_err      = 1'b1;
        done_err_code = err_code_q;
      end
      default: begin
        st_ctrl_active = 1'b0;
      end
    endcase
  end

  assign local_base  = local_base_q;
  assign frame_depth = lifo_count;

`ifdef FRAME_STATS_EN
  logic [FRAME_LOG2_DEPTH:0] max_depth_q, max_depth_d;
  logic [31:0]               call_count_q, call_count_d;
  logic [FRAME_LOG2_DEPTH:0] next_depth;

  assign next_depth = lifo_count + (FRAME_LOG2_DEPTH+1)'(1);

  always_comb begin
    max_depth_d  = max_depth_q;
    call_count_d = call_count_q;
    if (lifo_push) begin
      if (next_depth > max_depth_q) max_depth_d = next_depth;
      else max_depth_d = max_depth_q;
      if (call_count_q != 32'hFFFF_FFFF) call_count_d = call_count_q + 32'd1;
      else call_count_d = call_count_q;
    end else begin
      max_depth_d = max_depth_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_depth_q  <= '0;
      call_count_q <= 32'd0;
    end else begin
      max_depth_q  <= max_depth_d;
      call_count_q <= call_count_d;
    end
  end

  assign stat_max_depth  = max_depth_q;
  assign stat_call_count = call_count_q;
`else
  // Statistics outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_frame_controller.sv
// Directed, table-driven bench for frame_controller.
module tb_frame_controller;
  import wasm_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = 2'b00, req_result_num = 2'd0;
  logic [7:0]  req_param_num = 8'd0, req_local_num = 8'd0;
  logic [15:0] req_return_pc = 16'h0;
  logic [8:0]  st_top_pointer = 9'd0;
  logic [31:0] win_a = 32'd0, win_b = 32'd0, win_c = 32'd0;
  logic        st_ctrl_active, st_call, st_return, st_push_num;
  logic [7:0]  st_alloc_size;
  logic [31:0] st_function_stack_tag, st_push_data;
  logic [8:0]  local_base;
  logic [4:0]  frame_depth;
  logic        done_valid, done_err;
  logic [2:0]  done_err_code;
  logic [15:0] done_return_pc;
`ifdef FRAME_STATS_EN
  logic [4:0]  stat_max_depth;
  logic [31:0] stat_call_count;
`endif

  frame_controller dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_param_num(req_param_num), .req_local_num(req_local_num),
    .req_result_num(req_result_num), .req_return_pc(req_return_pc),
    .st_top_pointer(st_top_pointer), .st_pop_window_a(win_a),
    .st_pop_window_b(win_b), .st_pop_window_c(win_c),
    .st_ctrl_active(st_ctrl_active), .st_call(st_call), .st_return(st_return),
    .st_alloc_size(st_alloc_size), .st_function_stack_tag(st_function_stack_tag),
    .st_push_num(st_push_num), .st_push_data(st_push_data),
    .local_base(local_base), .frame_depth(frame_depth),
`ifdef FRAME_STATS_EN
    .stat_max_depth(stat_max_depth), .stat_call_count(stat_call_count),
`endif
    .done_valid(done_valid), .done_err(done_err),
    .done_err_code(done_err_code), .done_return_pc(done_return_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op; logic [7:0] p; logic [7:0] l; logic [1:0] r; logic [15:0] pc;
    logic [8:0] top; logic [31:0] a; logic [31:0] b; logic [31:0] c;
    int lat; logic err; logic [2:0] code; logic [15:0] rpc;
    int ncall; logic [7:0] alloc; int nret; logic [31:0] tag;
    int npush; logic [31:0] p0; logic [31:0] p1; logic [31:0] p2;
    logic [8:0] lb; logic [4:0] depth;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, ".req_ready"}, 64'(req_ready), 64'd1);
    chk({nm, ".active"}, 64'(st_ctrl_active), 64'd0);
    chk({nm, ".strobes"}, 64'({st_call, st_return, st_push_num}), 64'd0);
    chk({nm, ".st_data"}, 64'({st_alloc_size, st_function_stack_tag, st_push_data}), 64'd0);
    chk({nm, ".done"}, 64'({done_valid, done_err, done_err_code, done_return_pc}), 64'd0);
    chk({nm, ".local_base"}, 64'(local_base), 64'd0);
    chk({nm, ".frame_depth"}, 64'(frame_depth), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat = -1, ncall = 0, nret = 0, np = 0, bad = 0;
    logic [7:0]  alloc = 8'd0;
    logic [31:0] tag = 32'd0;
    logic [31:0] pd [3] = '{32'd0, 32'd0, 32'd0};
    logic        err = 1'b0;
    logic [2:0]  code = 3'd0;
    logic [15:0] rpc = 16'h0;
    req_op = v.op; req_param_num = v.p; req_local_num = v.l; req_result_num = v.r;
    req_return_pc = v.pc; st_top_pointer = v.top; win_a = v.a; win_b = v.b; win_c = v.c;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if ((st_call || st_return || st_push_num) && !st_ctrl_active) bad++;
      if (st_call) begin ncall++; alloc = st_alloc_size; end
      if (st_return) begin nret++; tag = st_function_stack_tag; end
      if (st_push_num) begin
        if (np < 3) pd[np] = st_push_data;
        np++;
      end
      if (done_valid) begin
        lat = cyc; err = done_err; code = done_err_code; rpc = done_return_pc;
        break;
      end
      tick();
    end
    tick();
    chk({nm, ".latency"}, 64'(lat), 64'(v.lat));
    chk({nm, ".err"}, 64'(err), 64'(v.err));
    chk({nm, ".code"}, 64'(code), 64'(v.code));
    chk({nm, ".return_pc"}, 64'(rpc), 64'(v.rpc));
    chk({nm, ".calls"}, 64'(ncall), 64'(v.ncall));
    chk({nm, ".alloc"}, 64'(alloc), 64'(v.alloc));
    chk({nm, ".returns"}, 64'(nret), 64'(v.nret));
    chk({nm, ".tag"}, 64'(tag), 64'(v.tag));
    chk({nm, ".pushes"}, 64'(np), 64'(v.npush));
    chk({nm, ".push_data"}, {pd[0], pd[1]}, {v.p0, v.p1});
    chk({nm, ".push_data2"}, 64'(pd[2]), 64'(v.p2));
    chk({nm, ".inactive_strobe"}, 64'(bad), 64'd0);
    chk({nm, ".local_base"}, 64'(local_base), 64'(v.lb));
    chk({nm, ".frame_depth"}, 64'(frame_depth), 64'(v.depth));
    chk({nm, ".ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    vec_t v;
    //        op    p     l      r     pc        top     a        b        c       lat err code rpc       nc alloc nr tag     np p0       p1       p2     lb      depth
    vt[0]  = '{2'b01, 8'd2, 8'd3,  2'd1, 16'h0040, 9'd5,   32'd0,   32'd0,   32'd0,   2, 1'b0, 3'd0, 16'h0,    1, 8'd3, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd3,   5'd1};
    vt[1]  = '{2'b10, 8'd0, 8'd0,  2'd0, 16'h0,    9'd9,   32'hAA,  32'hBB,  32'hCC,  4, 1'b0, 3'd0, 16'h0040, 0, 8'd0, 1, 32'd3,   1, 32'hAA,  32'd0,   32'd0, 9'd0,   5'd0};
    vt[2]  = '{2'b10, 8'd0, 8'd0,  2'd0, 16'h0,    9'd9,   32'd0,   32'd0,   32'd0,   1, 1'b1, 3'd2, 16'h0,    0, 8'd0, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd0,   5'd0};
    vt[3]  = '{2'b01, 8'd1, 8'd0,  2'd3, 16'h0123, 9'd10,  32'd0,   32'd0,   32'd0,   2, 1'b0, 3'd0, 16'h0,    1, 8'd0, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd9,   5'd1};
    vt[4]  = '{2'b10, 8'd0, 8'd0,  2'd0, 16'h0,    9'd12,  32'd1,   32'd2,   32'd3,   6, 1'b0, 3'd0, 16'h0123, 0, 8'd0, 1, 32'd9,   3, 32'd3,   32'd2,   32'd1, 9'd0,   5'd0};
    vt[5]  = '{2'b01, 8'd4, 8'd0,  2'd0, 16'h0,    9'd2,   32'd0,   32'd0,   32'd0,   1, 1'b1, 3'd3, 16'h0,    0, 8'd0, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd0,   5'd0};
    vt[6]  = '{2'b01, 8'd0, 8'd10, 2'd0, 16'h0,    9'd250, 32'd0,   32'd0,   32'd0,   1, 1'b1, 3'd4, 16'h0,    0, 8'd0, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd0,   5'd0};
    vt[7]  = '{2'b01, 8'd0, 8'd6,  2'd2, 16'h0055, 9'd250, 32'd0,   32'd0,   32'd0,   2, 1'b0, 3'd0, 16'h0,    1, 8'd6, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd250, 5'd1};
    vt[8]  = '{2'b10, 8'd0, 8'd0,  2'd0, 16'h0,    9'd251, 32'd0,   32'd0,   32'd0,   1, 1'b1, 3'd5, 16'h0,    0, 8'd0, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd250, 5'd1};
    vt[9]  = '{2'b00, 8'd0, 8'd0,  2'd0, 16'h0,    9'd251, 32'd0,   32'd0,   32'd0,   1, 1'b1, 3'd6, 16'h0,    0, 8'd0, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd250, 5'd1};
    vt[10] = '{2'b11, 8'd0, 8'd0,  2'd0, 16'h0,    9'd251, 32'd0,   32'd0,   32'd0,   1, 1'b1, 3'd6, 16'h0,    0, 8'd0, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd250, 5'd1};
    vt[11] = '{2'b10, 8'd0, 8'd0,  2'd0, 16'h0,    9'd252, 32'h11,  32'h22,  32'h33,  5, 1'b0, 3'd0, 16'h0055, 0, 8'd0, 1, 32'd250, 2, 32'h22,  32'h11,  32'd0, 9'd0,   5'd0};
    vt[12] = '{2'b01, 8'd3, 8'd0,  2'd0, 16'h0007, 9'd3,   32'd0,   32'd0,   32'd0,   2, 1'b0, 3'd0, 16'h0,    1, 8'd0, 0, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd0,   5'd1};
    vt[13] = '{2'b10, 8'd0, 8'd0,  2'd0, 16'h0,    9'd0,   32'd0,   32'd0,   32'd0,   3, 1'b0, 3'd0, 16'h0007, 0, 8'd0, 1, 32'd0,   0, 32'd0,   32'd0,   32'd0, 9'd0,   5'd0};

    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();
    check_idle_zero("idle");

    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Fill the frame LIFO to capacity, then one more CALL must overflow.
    for (int i = 0; i < 17; i++) begin
      v = '{2'b01, 8'd0, 8'd0, 2'd0, 16'h0, 9'd0, 32'd0, 32'd0, 32'd0,
            2, 1'b0, 3'd0, 16'h0, 1, 8'd0, 0, 32'd0, 0, 32'd0, 32'd0, 32'd0, 9'd0, 5'(i + 1)};
      if (i == 16) begin
        v.lat = 1; v.err = 1'b1; v.code = 3'd1; v.ncall = 0; v.depth = 5'd16;
      end
      run_vec(v, $sformatf("fill%0d", i));
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("reset2");

    // Reset landing in the middle of a RETURN result push.
    v = '{2'b01, 8'd0, 8'd0, 2'd3, 16'h0009, 9'd3, 32'd0, 32'd0, 32'd0,
          2, 1'b0, 3'd0, 16'h0, 1, 8'd0, 0, 32'd0, 0, 32'd0, 32'd0, 32'd0, 9'd3, 5'd1};
    run_vec(v, "pre_rst_call");
    req_op = 2'b10; st_top_pointer = 9'd6;
    win_a = 32'h0A; win_b = 32'h0B; win_c = 32'h0C;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rst_seq.cap_idle_stack", 64'({st_ctrl_active, st_return, st_push_num}), 64'd0);
    tick();
    chk("rst_seq.unwind", 64'({st_ctrl_active, st_return}), 64'b11);
    chk("rst_seq.unwind_tag", 64'(st_function_stack_tag), 64'd3);
    tick();
    chk("rst_seq.push", 64'({st_ctrl_active, st_push_num}), 64'b11);
    chk("rst_seq.push_data", 64'(st_push_data), 64'h0C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("rst_seq.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
